// File: rtl/sd_pkg.sv
// Shared types and default constants for the SD pixel burst writer.
package sd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } sd_state_e;

    localparam int unsigned SD_BURST_LEN   = 256;
    localparam int unsigned SD_FRAME_WORDS = 384000;
    localparam int unsigned SD_HDR_WORDS   = 27;

endpackage

// File: rtl/sd_sync_fifo.sv
// Synchronous first-word fall-through FIFO; head word is visible on rdata while not empty.
module sd_sync_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        pop,
    output logic [DATA_W-1:0]           rdata,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_push, do_pop;

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        full     = (level == (AW+1)'(FIFO_DEPTH));
        empty    = (level == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        // Force zero when empty so the output is defined out of reset.
        rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sd_pixel_burst_writer.sv
// Buffers SD pixel words and issues linear SDRAM write bursts, with a short final burst per picture.
// Optional SD_BMP_HDR_SKIP_EN drops the first HDR_WORDS accepted words after reset and after each frame.
module sd_pixel_burst_writer
    import sd_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 24,
    parameter int BURST_LEN   = SD_BURST_LEN,
    parameter int FIFO_DEPTH  = 512,
    parameter int FRAME_WORDS = SD_FRAME_WORDS
`ifdef SD_BMP_HDR_SKIP_EN
    ,
    parameter int HDR_WORDS   = SD_HDR_WORDS
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       init_i,
    input  logic                       sd_valid,
    input  logic [DATA_W-1:0]          sd_data,
    input  logic                       pic_read_done,
    output logic                       wr_req,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [$clog2(BURST_LEN):0] wr_len,
    input  logic                       wr_ack,
    input  logic                       wr_data_en,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       frame_done,
    output logic                       ovf
);

    localparam int LEN_W = $clog2(BURST_LEN) + 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    sd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              done_seen_q, done_seen_d;
    logic              pic_q;
    logic              ovf_q, ovf_d;

    logic              accept, push, xfer_pop, pic_rise;
    logic              full, empty;
    logic [LVL_W-1:0]  level;
    logic [ADDR_W:0]   addr_sum, addr_next;

    assign accept   = sd_valid && init_i;
    assign pic_rise = pic_read_done && !pic_q;
    assign xfer_pop = (state_q == XFER) && wr_data_en && !empty;

`ifdef SD_BMP_HDR_SKIP_EN
    localparam int HC_W = (HDR_WORDS > 0) ? $clog2(HDR_WORDS + 1) : 1;

    logic [HC_W-1:0] hdr_cnt_q, hdr_cnt_d;
    logic            in_hdr;

    always_comb begin
        in_hdr    = (hdr_cnt_q < HC_W'(HDR_WORDS));
        hdr_cnt_d = hdr_cnt_q;
        if (state_q == DONE)       hdr_cnt_d = '0;
        else if (accept && in_hdr) hdr_cnt_d = hdr_cnt_q + HC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hdr_cnt_q <= '0;
        else        hdr_cnt_q <= hdr_cnt_d;
    end

    // Header words are discarded before the FIFO, so they never raise ovf.
    assign push = accept && !in_hdr;
`else
    assign push = accept;
`endif

    sd_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (sd_data),
        .pop   (wr_data_en),
        .rdata (wr_data),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Linear address advance with wrap at the frame size.
    always_comb begin
        addr_sum  = {1'b0, addr_q} + (ADDR_W+1)'(len_q);
        addr_next = addr_sum;
        if (addr_sum >= (ADDR_W+1)'(FRAME_WORDS)) addr_next = addr_sum - (ADDR_W+1)'(FRAME_WORDS);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        done_seen_d = done_seen_q || pic_rise;
        ovf_d       = ovf_q || (push && full);
        wr_req      = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_i) begin
                    if (level >= LVL_W'(BURST_LEN)) begin
                        state_d = REQ;
                        len_d   = LEN_W'(BURST_LEN);
                        cnt_d   = '0;
                    end else if (done_seen_q && !empty) begin
                        state_d = REQ;
                        len_d   = LEN_W'(level);
                        cnt_d   = '0;
                    end else if (done_seen_q) begin
                        state_d     = DONE;
                        done_seen_d = pic_rise;
                    end
                end
            end
            REQ: begin
                wr_req = 1'b1;
                if (wr_ack) state_d = XFER;
            end
            XFER: begin
                if (xfer_pop) begin
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        state_d = IDLE;
                        addr_d  = addr_next[ADDR_W-1:0];
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                addr_d     = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            done_seen_q <= 1'b0;
            pic_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            done_seen_q <= done_seen_d;
            pic_q       <= pic_read_done;
            ovf_q       <= ovf_d;
        end
    end

    assign wr_addr = addr_q;
    assign wr_len  = len_q;
    assign ovf     = ovf_q;

endmodule

// File: doc/sd_pixel_burst_writer.md
# sd_pixel_burst_writer

Downstream stage of the SD card reader: accepts the 16-bit pixel word stream (`sd_valid`/`sd_data`) produced once SD initialisation completes, buffers it in an on-chip FIFO, and issues fixed-length write bursts with linear addresses to the SDRAM frame-buffer controller. It issues a short final burst when the picture read completes, then pulses `frame_done` so the display side can swap to the new frame.

## Interface
- `DATA_W`, 16, pixel word width
- `ADDR_W`, 24, SDRAM word-address width
- `BURST_LEN`, 256, full burst length in words (power of two)
- `FIFO_DEPTH`, 512, buffer depth in words (power of two, ≥ 2×BURST_LEN)
- `FRAME_WORDS`, 384000, words per frame (800×480); address wraps here
- `HDR_WORDS`, 27, BMP header words discarded (54 bytes); used only with `SD_BMP_HDR_SKIP_EN`

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `init_i`  in  1  SD init complete; while low the block holds in IDLE and ignores `sd_valid`
- `sd_valid`  in  1  one-cycle strobe, `sd_data` valid
- `sd_data`  in  DATA_W  pixel word
- `pic_read_done`  in  1  level, picture fully read; rising edge detected internally
- `wr_req`  out  1  burst request, held until `wr_ack`
- `wr_addr`  out  ADDR_W  burst start word address, stable while `wr_req` is high
- `wr_len`  out  log2(BURST_LEN)+1  words in this burst, 1..BURST_LEN
- `wr_ack`  in  1  one-cycle burst acceptance
- `wr_data_en`  in  1  controller pops one word this cycle
- `wr_data`  out  DATA_W  FIFO head (first-word fall-through)
- `frame_done`  out  1  one-cycle pulse after the last word of a picture is popped
- `ovf`  out  1  sticky: a word arrived while the FIFO was full

## Operation
- Push: `sd_valid && init_i && !full` writes `sd_data`. If full, the word is dropped and `ovf` is set; only reset clears `ovf`.
- Pop: `wr_data_en && !empty` advances the head. Pop on empty is ignored. Simultaneous push and pop leaves the level unchanged.
- `done_seen` is set on a rising edge of `pic_read_done` and cleared on entering DONE.
- FSM:
  - IDLE → REQ when level ≥ BURST_LEN, with `wr_len`=BURST_LEN.
  - IDLE → REQ when `done_seen` and 0 < level < BURST_LEN, with `wr_len`=level, latched.
  - IDLE → DONE when `done_seen` and level = 0.
  - REQ: `wr_req`=1. On `wr_ack` → XFER.
  - XFER: counts pops. The pop that reaches `wr_len` → IDLE, with `wr_addr` += `wr_len`. If the sum is ≥ FRAME_WORDS, it wraps by subtracting FRAME_WORDS.
  - DONE: `frame_done`=1 for one cycle and `wr_addr` is set to 0 → IDLE.
- `wr_data_en` outside XFER still pops. This is a protocol error by the controller and is not checked.
- `init_i` falling mid-operation: the current burst completes, and no new push is accepted.

## Timing
- Reset values: `wr_req`=0, `wr_addr`=0, `wr_len`=0, `wr_data`=0, `frame_done`=0, `ovf`=0. The FIFO is empty and the state is IDLE.
- A pushed word appears on `wr_data` the next cycle if the FIFO was empty.
- `wr_req` rises 1 cycle after the level reaches BURST_LEN (registered FSM).
- `wr_ack` is sampled only while `wr_req`=1. `wr_req` falls the cycle after `wr_ack`.
- `wr_data` is valid in every XFER cycle in which `wr_data_en` is high. `wr_data_en` may have gaps.
- `frame_done` occurs 2 cycles after the final pop (XFER→IDLE→DONE).
- Asynchronous reset mid-burst abandons the burst. Buffered data is lost.

## Configuration
- `SD_BMP_HDR_SKIP_EN` defined: after each reset and after each DONE, the first HDR_WORDS accepted words are discarded. They do not enter the FIFO and do not count toward `ovf`.
- `SD_BMP_HDR_SKIP_EN` undefined: every word is buffered, the skip counter is absent, and `HDR_WORDS` is unused.

## Structure
- Shared package `sd_pkg`:
  - FSM state enum (IDLE, REQ, XFER, DONE)
  - default constants for BURST_LEN, FRAME_WORDS, HDR_WORDS
- One sub-module `sd_sync_fifo`:
  - synchronous fall-through FIFO, parameters DATA_W and FIFO_DEPTH
  - outputs `level`, `full`, `empty`
- The top level holds the FSM, address/length logic, skip counter, and edge detect.

## Test plan
- 512 back-to-back words (0..511), `wr_ack` 2 cycles after each `wr_req`, `wr_data_en` continuous → two bursts at addr 0 and 256, data 0..511 in order, no `frame_done`.
- 300 words then `pic_read_done` rises → bursts of length 256 then 44 at addr 0 and 256, `frame_done` pulses once, next burst addr 0.
- Push 513 words with no `wr_ack` → `ovf`=1 from word 513, level stays 512, `wr_data`=word 0.
- FRAME_WORDS=384 with 2 full bursts → second burst at addr 256, third at addr 128 (wrap).
- `SD_BMP_HDR_SKIP_EN` with words 0..282 then done → one burst, length 256, first word 27; `frame_done` pulses.
- `rst_n` low during XFER after 100 pops → all outputs 0, FIFO empty, and the next 256 words burst at addr 0.
